// File: rtl/fpmult_pkg.sv
// Shared constants for the FP multiplier scheduler and the multiplier datapath it feeds.
package fpmult_pkg;

    localparam int unsigned LAT_DEFAULT   = 4;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned OP_W          = 32;
    localparam int unsigned EXC_W         = 7;
    localparam int unsigned RES_W         = EXC_W + OP_W;

endpackage

// File: rtl/fpmult_res_fifo.sv
// First-word-fall-through result FIFO, one per requester.
module fpmult_res_fifo
    import fpmult_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [RES_W-1:0]       push_d,
    input  logic                   pop,
    output logic                   vld,
    output logic [RES_W-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [RES_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;

    assign vld    = (wr_ptr != rd_ptr);
    assign pop_ok = pop & vld;
    assign head   = mem[rd_ptr[AW-1:0]];
    assign count  = wr_ptr - rd_ptr;

    // Pointers wrap modulo DEPTH; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_d;
        end
    end

endmodule

// File: rtl/fpmult_scheduler.sv
// Round-robin scheduler sharing one fixed-latency FP multiplier between two
// requesters, with credit-limited per-requester result FIFOs.
module fpmult_scheduler
    import fpmult_pkg::*;
#(
    parameter int unsigned LAT   = LAT_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        req_vld,
    output logic [1:0]        req_rdy,
    input  logic [OP_W-1:0]   req_a0,
    input  logic [OP_W-1:0]   req_b0,
    input  logic [OP_W-1:0]   req_a1,
    input  logic [OP_W-1:0]   req_b1,
    output logic              mul_vld,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [OP_W-1:0]   mul_res,
    input  logic [EXC_W-1:0]  mul_exc,
    input  logic              mul_res_vld,
    output logic [1:0]        res_vld,
    input  logic [1:0]        res_rdy,
    output logic [RES_W-1:0]  res_d0,
    output logic [RES_W-1:0]  res_d1,
    output logic              busy
);

    localparam int unsigned   CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

    logic [CW-1:0]    credit [2];
    logic [CW-1:0]    cnt0;
    logic [CW-1:0]    cnt1;
    logic [1:0]       elig;
    logic [1:0]       cand;
    logic [1:0]       grant;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             gid;
    logic             rr_ptr;
    logic [LAT-1:0]   tag_vld;
    logic [LAT-1:0]   tag_id;
    logic             tag_out_vld;
    logic             tag_out_id;
    logic             err;
    logic [RES_W-1:0] push_d;

    // Eligibility: a requester may issue only while it holds a free FIFO slot.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            elig[i] = (credit[i] < CREDIT_MAX);
        end
    end

    // Gating with rst_n keeps handshakes dead while reset is held.
    assign cand = req_vld & elig & {2{en & rst_n}};

    // Round-robin pick between the valid, eligible requesters.
    always_comb begin
        grant = cand;
        if (cand == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end
    end

    assign gid     = grant[1];
    assign req_rdy = grant;
    assign mul_vld = |grant;
    assign mul_a   = grant[1] ? req_a1 : (grant[0] ? req_a0 : '0);
    assign mul_b   = grant[1] ? req_b1 : (grant[0] ? req_b0 : '0);

    // Priority pointer flips to the other requester after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (mul_vld) begin
            rr_ptr <= ~gid;
        end
    end

    // Tag pipeline mirrors the multiplier so each result finds its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= mul_vld;
            tag_id[0]  <= gid;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    assign tag_out_vld = tag_vld[LAT-1];
    assign tag_out_id  = tag_id[LAT-1];
    assign push[0]     = tag_out_vld & mul_res_vld & ~tag_out_id;
    assign push[1]     = tag_out_vld & mul_res_vld & tag_out_id;
    assign push_d      = {mul_exc, mul_res};
    assign pop         = res_vld & res_rdy;

    // Sticky flag for a result strobe that disagrees with the tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err | (tag_out_vld ^ mul_res_vld);
        end
    end

    // Credits count in-flight plus buffered results, so FIFO pushes never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit[0] <= '0;
            credit[1] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                case ({grant[i], pop[i]})
                    2'b10:   credit[i] <= credit[i] + 1'b1;
                    2'b01:   credit[i] <= credit[i] - 1'b1;
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

    fpmult_res_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push[0]),
        .push_d (push_d),
        .pop    (pop[0]),
        .vld    (res_vld[0]),
        .head   (res_d0),
        .count  (cnt0)
    );

    fpmult_res_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push[1]),
        .push_d (push_d),
        .pop    (pop[1]),
        .vld    (res_vld[1]),
        .head   (res_d1),
        .count  (cnt1)
    );

    assign busy = (|tag_vld) | (cnt0 != '0) | (cnt1 != '0)
                | (credit[0] != '0) | (credit[1] != '0);

endmodule

// File: tb/tb_fpmult_scheduler.sv
// Scoreboard bench for fpmult_scheduler with a fixed-latency multiplier model.
module tb_fpmult_scheduler;
    import fpmult_pkg::*;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          NV    = 8;

    // Hand-computed single-precision products.
    localparam logic [31:0] VA [NV] = '{32'h3F800000, 32'h40400000, 32'hBF800000, 32'h3F000000,
                                        32'h7FC00000, 32'h40000000, 32'h40E00000, 32'hC0000000};
    localparam logic [31:0] VB [NV] = '{32'h40000000, 32'h40800000, 32'h40A00000, 32'h3F000000,
                                        32'h3F800000, 32'h40000000, 32'h41000000, 32'hC0400000};
    localparam logic [31:0] VR [NV] = '{32'h40000000, 32'h41400000, 32'hC0A00000, 32'h3E800000,
                                        32'h7FC00000, 32'h40800000, 32'h42600000, 32'h40C00000};
    localparam logic [6:0]  VX [NV] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h41, 7'h00, 7'h00, 7'h00};
    localparam int STALL_EXP [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [1:0]       req_vld;
    logic [1:0]       req_rdy;
    logic [31:0]      req_a0, req_b0, req_a1, req_b1;
    logic             mul_vld;
    logic [31:0]      mul_a, mul_b, mul_res;
    logic [6:0]       mul_exc;
    logic             mul_res_vld;
    logic [1:0]       res_vld;
    logic [1:0]       res_rdy;
    logic [RES_W-1:0] res_d0, res_d1;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int               src_q0 [$];
    int               src_q1 [$];
    logic [RES_W-1:0] exp_q0 [$];
    logic [RES_W-1:0] exp_q1 [$];
    int               gl  [$];
    int               gc  [$];
    int               rc0 [$];

    fpmult_scheduler #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .mul_vld     (mul_vld),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_res     (mul_res),
        .mul_exc     (mul_exc),
        .mul_res_vld (mul_res_vld),
        .res_vld     (res_vld),
        .res_rdy     (res_rdy),
        .res_d0      (res_d0),
        .res_d1      (res_d1),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: LAT-stage pipe, product looked up from the vector table.
    logic        mp_v [LAT];
    logic [31:0] mp_a [LAT];
    logic [31:0] mp_b [LAT];

    always @(posedge clk) begin
        mp_v[0] <= mul_vld;
        mp_a[0] <= mul_a;
        mp_b[0] <= mul_b;
        for (int s = 1; s < LAT; s++) begin
            mp_v[s] <= mp_v[s-1];
            mp_a[s] <= mp_a[s-1];
            mp_b[s] <= mp_b[s-1];
        end
    end

    function automatic logic [38:0] mult_lookup(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < NV; k++) begin
            if (a == VA[k] && b == VB[k]) return {VX[k], VR[k]};
        end
        return {7'h7F, 32'hDEADBEEF};
    endfunction

    always_comb begin
        mul_res_vld        = mp_v[LAT-1];
        {mul_exc, mul_res} = mp_v[LAT-1] ? mult_lookup(mp_a[LAT-1], mp_b[LAT-1]) : 39'h0;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive();
        req_vld[0] = (src_q0.size() != 0);
        req_vld[1] = (src_q1.size() != 0);
        req_a0 = req_vld[0] ? VA[src_q0[0]] : 32'h0;
        req_b0 = req_vld[0] ? VB[src_q0[0]] : 32'h0;
        req_a1 = req_vld[1] ? VA[src_q1[0]] : 32'h0;
        req_b1 = req_vld[1] ? VB[src_q1[0]] : 32'h0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            drive();
        end
    end

    // Monitor: interface invariants, handshakes push expectations, result pops compare.
    always @(negedge clk) begin
        logic [63:0] exp_ops;
        if (rst_n) begin
            exp_ops = req_rdy[0] ? {req_a0, req_b0} : (req_rdy[1] ? {req_a1, req_b1} : 64'h0);
            check("mul_vld_eq_grant", mul_vld, |req_rdy);
            check("grant_onehot", (req_rdy != 2'b11), 1);
            check("rdy_without_vld", req_rdy & ~req_vld, 0);
            check("mul_operands", {mul_a, mul_b}, exp_ops);
            if (req_vld[0] && req_rdy[0]) begin
                exp_q0.push_back({VX[src_q0[0]], VR[src_q0[0]]});
                void'(src_q0.pop_front());
                gl.push_back(0);
                gc.push_back(cyc);
            end
            if (req_vld[1] && req_rdy[1]) begin
                exp_q1.push_back({VX[src_q1[0]], VR[src_q1[0]]});
                void'(src_q1.pop_front());
                gl.push_back(1);
                gc.push_back(cyc);
            end
            if (res_vld[0] && res_rdy[0]) begin
                if (exp_q0.size() == 0) check("res0_unexpected", res_vld[0], 0);
                else check("res0_data", res_d0, exp_q0.pop_front());
                rc0.push_back(cyc);
            end
            if (res_vld[1] && res_rdy[1]) begin
                if (exp_q1.size() == 0) check("res1_unexpected", res_vld[1], 0);
                else check("res1_data", res_d1, exp_q1.pop_front());
            end
        end
    end

    task automatic wait_grants(input int n, input int budget);
        int t = 0;
        while (gl.size() < n && t < budget) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("grant_wait", (gl.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        bit done = 1'b0;
        while (!done && t < budget) begin
            @(negedge clk);
            #1;
            done = !busy && src_q0.size() == 0 && src_q1.size() == 0
                   && exp_q0.size() == 0 && exp_q1.size() == 0;
            t++;
        end
        check("drain", done, 1);
    endtask

    task automatic clear_bench();
        src_q0.delete(); src_q1.delete();
        exp_q0.delete(); exp_q1.delete();
        gl.delete(); gc.delete(); rc0.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_bench();
        drive();
        repeat (LAT + 2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        res_rdy = 2'b11;
        clear_bench();

        // Reset state with a request already pending, then single issue.
        src_q0.push_back(0);
        drive();
        repeat (LAT + 2) @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_mul_vld", mul_vld, 0);
        check("rst_res_vld", res_vld, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant_after_rst", req_rdy, 2'b01);
        wait_idle(40);
        check("single_nres", rc0.size(), 1);
        if (gc.size() > 0 && rc0.size() > 0) check("single_latency", rc0[0] - gc[0], LAT + 1);

        // Contention: strict alternation from requester 0, back to back.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            src_q0.push_back(j);
            src_q1.push_back(j + 4);
        end
        drive();
        wait_idle(80);
        check("cont_ngrants", gl.size(), 8);
        for (int j = 0; j < gl.size(); j++) begin
            check("cont_order", gl[j], j % 2);
            check("cont_back2back", gc[j] - gc[0], j);
        end

        // Credit stall on requester 0.
        do_reset();
        res_rdy = 2'b10;
        src_q0  = '{0, 1, 2, 3, 5, 6};
        src_q1  = '{7, 5, 3, 1, 0, 2};
        drive();
        repeat (20) @(posedge clk);
        #2;
        check("stall_ngrants", gl.size(), 10);
        for (int j = 0; j < gl.size() && j < 10; j++) check("stall_order", gl[j], STALL_EXP[j]);
        @(negedge clk);
        check("stall_rdy0", req_rdy[0], 0);
        check("stall_occ0", dut.u_fifo0.count, DEPTH);
        check("stall_src0_left", src_q0.size(), 2);

        // Push and pop together on FIFO 0 at occupancy DEPTH-1.
        @(posedge clk);
        #2;
        res_rdy[0] = 1'b1;
        @(posedge clk);
        #2;
        res_rdy[0] = 1'b0;
        wait_grants(gl.size() + 1, 10);
        repeat (LAT - 1) @(posedge clk);
        #2;
        res_rdy[0] = 1'b1;
        @(negedge clk);
        check("sim_push_cycle", mul_res_vld, 1);
        check("sim_occ_before", dut.u_fifo0.count, DEPTH - 1);
        @(posedge clk);
        #2;
        res_rdy[0] = 1'b0;
        @(negedge clk);
        check("sim_occ_after", dut.u_fifo0.count, DEPTH - 1);
        @(posedge clk);
        #2;
        res_rdy = 2'b11;
        wait_idle(80);

        // en dropped after two issues.
        @(posedge clk);
        #2;
        gl.delete();
        src_q0 = '{1, 3, 5, 7};
        drive();
        wait_grants(2, 20);
        en = 1'b0;
        @(negedge clk);
        check("en_busy_high", busy, 1);
        repeat (3 * LAT) @(negedge clk);
        check("en_no_issue", gl.size(), 2);
        check("en_mul_vld", mul_vld, 0);
        check("en_pending", src_q0.size(), 2);
        check("en_delivered", exp_q0.size(), 0);
        check("en_busy_low", busy, 0);
        @(posedge clk);
        #2;
        en = 1'b1;
        wait_idle(60);
        check("err_after_traffic", dut.err, 0);

        // Reset with three operations in flight.
        @(posedge clk);
        #2;
        gl.delete();
        src_q0 = '{0, 2, 4};
        src_q1 = '{1, 3};
        drive();
        wait_grants(3, 20);
        rst_n = 1'b0;
        clear_bench();
        drive();
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_res_vld", res_vld, 0);
        check("midrst_req_rdy", req_rdy, 0);
        repeat (LAT + 2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (LAT + 4) begin
            @(negedge clk);
            check("post_rst_busy", busy, 0);
            check("post_rst_res_vld", res_vld, 0);
        end
        check("post_rst_err", dut.err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpmult_scheduler.md
FPMULT_SCHEDULER -- requirements
Module: fpmult_scheduler

Interface
REQ-001 SHALL have parameter LAT, default 4: fixed latency in cycles from mul_vld issue to mul_res_vld of the shared FP multiplier pipeline, legal range 1..8.
REQ-002 SHALL have parameter DEPTH, default 4: per-requester result FIFO depth and credit limit, a power of two in the range 2..16.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  issue enable; when low, no new issue occurs but in-flight operations drain.
- req_vld[1:0]  in  2  per-requester operand valid.
- req_rdy[1:0]  out  2  per-requester operand accepted this cycle.
- req_a0, req_b0, req_a1, req_b1  in  32 each  IEEE-754 single-precision operands, per requester.
- mul_vld  out  1  issue strobe to the multiplier.
- mul_a, mul_b  out  32 each  muxed operands.
- mul_res  in  32  product.
- mul_exc  in  7  multiplier input-exception vector, passed through unchanged.
- mul_res_vld  in  1  result strobe from the multiplier.
- res_vld[1:0]  out  2  per-requester result valid.
- res_rdy[1:0]  in  2  per-requester result accept.
- res_d0, res_d1  out  39 each  {exc[6:0], res[31:0]}.
- busy  out  1  any operation in flight or any FIFO non-empty.

Function
REQ-004 An operation SHALL issue on a cycle iff en=1, at least one eligible requester has req_vld=1, and at most one operation issues per cycle.
REQ-005 Requester i SHALL be eligible iff credit[i] < DEPTH, where credit[i] = in-flight count for i plus FIFO i occupancy.
REQ-006 Arbitration SHALL be round-robin: when both requesters are eligible and valid, the one indicated by rr_ptr wins; after every grant, rr_ptr SHALL point to the other requester; rr_ptr SHALL be unchanged when nothing is granted.
REQ-007 req_rdy[i] SHALL be combinational and high only in the cycle requester i is granted; a handshake is req_vld[i] and req_rdy[i] both high.
REQ-008 mul_vld SHALL equal "any grant"; mul_a and mul_b SHALL carry the granted requester's operands in the same cycle, and SHALL be 0 when mul_vld=0.
REQ-009 A LAT-stage tag shift register {valid, id} SHALL record each issue; at stage LAT the tag SHALL route mul_res/mul_exc into FIFO id.
REQ-010 A mul_res_vld that is not matched by a valid tag, or a missing mul_res_vld on a valid tag, SHALL set a sticky internal error bit; the result SHALL be dropped in the former case and nothing pushed in the latter.
REQ-011 credit[i] SHALL increment on a grant to i, decrement on a FIFO-i pop (res_vld[i] and res_rdy[i] both high), and stay unchanged when both occur in the same cycle.
REQ-012 Because of credits, a FIFO push SHALL never find the FIFO full; pushes are never back-pressured.
REQ-013 Each FIFO SHALL be first-word-fall-through: res_vld[i] = not empty, and res_d[i] = head entry. A push and a pop in the same cycle are legal at any occupancy, including empty-with-push (pop is not allowed on empty).
REQ-014 FIFO read/write pointers SHALL wrap modulo DEPTH; an extra pointer bit SHALL distinguish full from empty.
REQ-015 Results per requester SHALL emerge in issue order; there is no ordering guarantee across requesters.
REQ-016 busy SHALL be registered-derived: the OR of tag valids, nonzero FIFO occupancies and nonzero credits.
REQ-017 Dropping en mid-stream SHALL NOT affect in-flight tags or FIFO contents.

Reset
REQ-018 On rst_n low, the block SHALL asynchronously clear tag valids, credits, FIFO pointers, rr_ptr (to 0) and the error bit; req_rdy, mul_vld, res_vld and busy SHALL be 0 while reset is asserted.
REQ-019 Results returning after reset is asserted mid-operation SHALL be discarded.
REQ-020 The first grant after reset SHALL be possible on the first clk edge following rst_n release.

Structure
REQ-021 A shared package/include SHALL hold the default LAT and DEPTH values, the result width (39), and the exception-vector width (7), for use alongside the multiplier modules.
REQ-022 The per-requester FIFO SHALL be a separate sub-module, fpmult_res_fifo, instantiated twice.

Verification
REQ-023 The bench SHALL use a LAT-cycle multiplier model and cover the following directed scenarios:
- Single issue: req0 0x3F800000 x 0x40000000 -> mul_vld in cycle 0, res_vld[0] in cycle LAT+1 with res_d0[31:0]=0x40000000 and exc=0.
- Contention: both requesters valid continuously, res_rdy=2'b11 -> grants alternate 0,1,0,1 starting at requester 0 after reset.
- Credit stall: res_rdy[0]=0, req0 always valid -> exactly DEPTH grants to 0, then req_rdy[0]=0; requester 1 still granted every cycle.
- Simultaneous: push and pop on FIFO 0 at occupancy DEPTH-1 -> occupancy unchanged, data order preserved.
- en toggle: en=0 after 2 issues -> no further mul_vld, both results delivered, busy falls once FIFOs are empty.
- Reset mid-flight: rst_n low with 3 in flight -> after release, busy=0, no res_vld, error bit clear.
